// File: rtl/multicycle_controller.sv
// Multicycle instruction controller: steps each instruction through fetch,
// decode, execute and an optional data-memory phase with a bounded wait.
module multicycle_controller #(
    parameter int INSTR_W     = 16,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                cond,
    input  logic                mem_ack,
    output logic                instr_req,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                sel_ALUScr_reg,
    output logic                sel_ALUScr_const,
    output logic                sel_PCSrc_plus1,
    output logic                sel_PCSrc_offset,
    output logic                sel_PCSrc_const,
    output logic                pc_we,
    output logic                rf_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                error
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Only the opcode field of the instruction word matters here.
    if (INSTR_W > 6) begin : g_instr_unused
        logic instr_unused;
        assign instr_unused = ^instruction[INSTR_W-7:0];
    end

    logic is_r, is_i, is_cj, is_j, is_ld, is_st, is_halt;
    assign is_r    = (opcode_q[5:4] == 2'b00);
    assign is_i    = (opcode_q[5:4] == 2'b01);
    assign is_cj   = (opcode_q[5:3] == 3'b100);
    assign is_j    = (opcode_q[5:2] == 4'b1010);
    assign is_ld   = (opcode_q == 6'b101100);
    assign is_st   = (opcode_q == 6'b101101);
    assign is_halt = (opcode_q == 6'b111111);

    always_comb begin
        state_d          = state_q;
        opcode_d         = opcode_q;
        cnt_d            = cnt_q;
        instr_req        = 1'b0;
        alu_op           = '0;
        sel_ALUScr_reg   = 1'b0;
        sel_ALUScr_const = 1'b0;
        sel_PCSrc_plus1  = 1'b0;
        sel_PCSrc_offset = 1'b0;
        sel_PCSrc_const  = 1'b0;
        pc_we            = 1'b0;
        rf_we            = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        halted           = 1'b0;
        error            = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    opcode_d = instruction[INSTR_W-1 -: 6];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_halt)
                    state_d = S_HALT;
                else if (is_r || is_i || is_cj || is_j || is_ld || is_st)
                    state_d = S_EXEC;
                else
                    state_d = S_ERROR;
            end
            S_EXEC: begin
                if (is_r || is_i) begin
                    sel_ALUScr_reg   = is_r;
                    sel_ALUScr_const = is_i;
                    alu_op           = opcode_q[ALU_OP_W-1:0];
                    rf_we            = 1'b1;
                    pc_we            = 1'b1;
                    sel_PCSrc_plus1  = 1'b1;
                    state_d          = S_FETCH;
                end else if (is_cj) begin
                    pc_we            = 1'b1;
                    sel_PCSrc_offset = cond;
                    sel_PCSrc_plus1  = ~cond;
                    state_d          = S_FETCH;
                end else if (is_j) begin
                    pc_we           = 1'b1;
                    sel_PCSrc_const = 1'b1;
                    state_d         = S_FETCH;
                end else if (is_ld || is_st) begin
                    sel_ALUScr_const = 1'b1;
                    cnt_d            = '0;
                    state_d          = S_MEM;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_MEM: begin
                // Address selects stay asserted so the ALU output is stable.
                mem_req          = 1'b1;
                mem_we           = is_st;
                sel_ALUScr_const = 1'b1;
                if (mem_ack) begin
                    pc_we           = 1'b1;
                    sel_PCSrc_plus1 = 1'b1;
                    rf_we           = is_ld;
                    state_d         = S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: error  = 1'b1;
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// hand-written reset corner cases and randomized instruction streams.
module tb_multicycle_controller;
    localparam int TMO = 15;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, instr_valid, cond, mem_ack;
    logic [15:0] instruction;
    logic        instr_req, sel_ALUScr_reg, sel_ALUScr_const;
    logic        sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const;
    logic        pc_we, rf_we, mem_req, mem_we, halted, error;
    logic [2:0]  alu_op;

    multicycle_controller #(.INSTR_W(16), .ALU_OP_W(3), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .instr_valid(instr_valid),
        .instruction(instruction), .cond(cond), .mem_ack(mem_ack),
        .instr_req(instr_req), .alu_op(alu_op),
        .sel_ALUScr_reg(sel_ALUScr_reg), .sel_ALUScr_const(sel_ALUScr_const),
        .sel_PCSrc_plus1(sel_PCSrc_plus1), .sel_PCSrc_offset(sel_PCSrc_offset),
        .sel_PCSrc_const(sel_PCSrc_const), .pc_we(pc_we), .rf_we(rf_we),
        .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .error(error)
    );

    // Observed output word: {instr_req, alu_op[2:0], 11 single-bit outputs}.
    logic [14:0] obs;
    assign obs = {instr_req, alu_op, sel_ALUScr_reg, sel_ALUScr_const, sel_PCSrc_plus1,
                  sel_PCSrc_offset, sel_PCSrc_const, pc_we, rf_we, mem_req, mem_we,
                  halted, error};

    localparam logic [14:0] O_IREQ = 15'h4000, O_SREG = 15'h0400, O_SCONST = 15'h0200;
    localparam logic [14:0] O_P1 = 15'h0100, O_POFF = 15'h0080, O_PCONST = 15'h0040;
    localparam logic [14:0] O_PCWE = 15'h0020, O_RFWE = 15'h0010, O_MREQ = 15'h0008;
    localparam logic [14:0] O_MWE = 15'h0004, O_HALT = 15'h0002, O_ERR = 15'h0001;

    // exp_end: 0 back to fetch, 1 halt, 2 illegal -> error, 3 memory phase
    typedef struct {
        string       name;
        logic [5:0]  op;
        bit          cnd;
        int          ack_at;
        logic [14:0] exp_exec;
        int          exp_end;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input string n, input logic [5:0] op, input bit c,
                                input int a, input logic [14:0] e, input int en);
        vec_t v;
        v.name = n; v.op = op; v.cnd = c; v.ack_at = a; v.exp_exec = e; v.exp_end = en;
        return v;
    endfunction

    task automatic chk(input string name, input logic [14:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic cyc(input string name, input logic [14:0] exp);
        #2;
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic sticky(input string tag, input logic [14:0] exp);
        for (int s = 0; s < 3; s++) begin
            start = 1'b1; instr_valid = 1'b1; mem_ack = 1'b1; cond = 1'($urandom);
            cyc({tag, "/sticky"}, exp);
        end
        start = 1'b0; instr_valid = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; start = 1'b1; mem_ack = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; instr_valid = 1'b1; mem_ack = 1'b1; cond = 1'b1;
        instruction = 16'hffff;
        #2;
        chk({tag, "/reset"}, 15'h0);
        @(posedge clk);
        #1;
        cyc({tag, "/idle"}, 15'h0);
        start = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; cond = 1'b0;
        cyc({tag, "/start"}, 15'h0);
        start = 1'b0;
        $display("reset %s done", tag);
    endtask

    // Runs one instruction from FETCH; terminal=1 when it ends in HALT/ERROR.
    task automatic run_instr(input string tag, input logic [5:0] op, input bit cnd,
                             input int stall, input int ack_at, input logic [14:0] exp_exec,
                             input int exp_end, output bit terminal);
        logic [14:0] base;
        bit acked;
        terminal = 1'b0;
        for (int s = 0; s < stall; s++) begin
            instr_valid = 1'b0; instruction = 16'($urandom);
            start = 1'($urandom); mem_ack = 1'($urandom);
            cyc({tag, "/stall"}, O_IREQ);
        end
        instr_valid = 1'b1; instruction = {op, 10'($urandom)};
        start = 1'($urandom); mem_ack = 1'($urandom);
        cyc({tag, "/fetch"}, O_IREQ);
        instr_valid = 1'b0; instruction = 16'($urandom);
        cond = 1'($urandom); mem_ack = 1'($urandom); start = 1'($urandom);
        cyc({tag, "/decode"}, 15'h0);
        if (exp_end == 1 || exp_end == 2) begin
            cyc({tag, "/final"}, (exp_end == 1) ? O_HALT : O_ERR);
            sticky(tag, (exp_end == 1) ? O_HALT : O_ERR);
            terminal = 1'b1;
        end else begin
            cond = cnd; mem_ack = 1'($urandom);
            cyc({tag, "/exec"}, exp_exec);
            mem_ack = 1'b0;
            if (exp_end == 3) begin
                base  = O_MREQ | O_SCONST | ((op == 6'b101101) ? O_MWE : 15'h0);
                acked = 1'b0;
                for (int k = 0; k <= TMO && !acked; k++) begin
                    cond = 1'($urandom); start = 1'($urandom);
                    mem_ack = (k == ack_at);
                    if (k == ack_at) begin
                        cyc({tag, "/mem_ack"}, base | O_PCWE | O_P1 |
                            ((op == 6'b101100) ? O_RFWE : 15'h0));
                        acked = 1'b1;
                    end else begin
                        cyc({tag, "/mem_wait"}, base);
                    end
                end
                mem_ack = 1'b0;
                if (!acked) begin
                    cyc({tag, "/timeout"}, O_ERR);
                    sticky(tag, O_ERR);
                    terminal = 1'b1;
                end
            end
        end
        start = 1'b0;
        $display("instr %s op=%b cond=%0d stall=%0d ack_at=%0d", tag, op, cnd, stall, ack_at);
    endtask

    // Reference model: instruction class -> opcode and expected behaviour.
    // Classes: 0 R, 1 I, 2 CJ, 3 J, 4 LD, 5 ST, 6 HALT, 7 ILLEGAL.
    function automatic logic [5:0] gen_op(input int c);
        logic [5:0] r;
        r = 6'($urandom);
        case (c)
            0: return {2'b00, r[3:0]};
            1: return {2'b01, r[3:0]};
            2: return {3'b100, r[2:0]};
            3: return {4'b1010, r[1:0]};
            4: return 6'b101100;
            5: return 6'b101101;
            6: return 6'b111111;
            default: begin
                if (r[5]) return {5'b10111, r[1]};
                if (r[3:0] == 4'hf) return 6'b110000;
                return {2'b11, r[3:0]};
            end
        endcase
    endfunction

    function automatic logic [14:0] model_exec(input int c, input logic [5:0] op, input bit cnd);
        logic [14:0] alu;
        alu = {1'b0, op[2:0], 11'd0};
        case (c)
            0: return O_SREG | alu | O_RFWE | O_PCWE | O_P1;
            1: return O_SCONST | alu | O_RFWE | O_PCWE | O_P1;
            2: return O_PCWE | (cnd ? O_POFF : O_P1);
            3: return O_PCWE | O_PCONST;
            4, 5: return O_SCONST;
            default: return 15'h0;
        endcase
    endfunction

    function automatic int model_end(input int c);
        if (c <= 3) return 0;
        if (c <= 5) return 3;
        if (c == 6) return 1;
        return 2;
    endfunction

    vec_t tbl[12];

    initial begin
        bit term;
        tbl[0]  = mk("r_000101",  6'b000101, 1'b0, -1, 15'h2D30, 0);
        tbl[1]  = mk("r_001111",  6'b001111, 1'b1, -1, 15'h3D30, 0);
        tbl[2]  = mk("i_011010",  6'b011010, 1'b0, -1, 15'h1330, 0);
        tbl[3]  = mk("cj_taken",  6'b100010, 1'b1, -1, 15'h00A0, 0);
        tbl[4]  = mk("cj_not",    6'b100010, 1'b0, -1, 15'h0120, 0);
        tbl[5]  = mk("j_101001",  6'b101001, 1'b1, -1, 15'h0060, 0);
        tbl[6]  = mk("ld_wait3",  6'b101100, 1'b0,  2, 15'h0200, 3);
        tbl[7]  = mk("st_ack0",   6'b101101, 1'b0,  0, 15'h0200, 3);
        tbl[8]  = mk("st_ack16",  6'b101101, 1'b0, 15, 15'h0200, 3);
        tbl[9]  = mk("st_tmo",    6'b101101, 1'b0, -1, 15'h0200, 3);
        tbl[10] = mk("halt",      6'b111111, 1'b0, -1, 15'h0000, 1);
        tbl[11] = mk("illegal",   6'b110000, 1'b0, -1, 15'h0000, 2);

        rst = 1'b1; start = 1'b0; instr_valid = 1'b0; cond = 1'b0; mem_ack = 1'b0;
        instruction = '0;
        @(posedge clk);
        #1;
        do_reset("init");

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].op, tbl[i].cnd, 0, tbl[i].ack_at,
                      tbl[i].exp_exec, tbl[i].exp_end, term);
            if (term) do_reset(tbl[i].name);
        end

        // Reset in the middle of an LD memory wait, with ack present.
        instr_valid = 1'b1; instruction = {6'b101100, 10'h155};
        cyc("rst_mem/fetch", O_IREQ);
        instr_valid = 1'b0;
        cyc("rst_mem/decode", 15'h0);
        cyc("rst_mem/exec", O_SCONST);
        cyc("rst_mem/mem_wait", O_MREQ | O_SCONST);
        do_reset("rst_mem");
        run_instr("after_rst_mem", 6'b000011, 1'b0, 0, -1, 15'h1D30, 0, term);

        // Reset while FETCH is stalled.
        instr_valid = 1'b0;
        cyc("rst_fetch/stall", O_IREQ);
        do_reset("rst_fetch");
        run_instr("after_rst_fetch", 6'b101010, 1'b0, 1, -1, 15'h0060, 0, term);

        // Randomized instruction stream against the class-level model.
        for (int n = 0; n < 80; n++) begin
            int c, ack, stall;
            bit cnd;
            logic [5:0] op;
            c     = $urandom_range(0, 7);
            cnd   = 1'($urandom);
            stall = $urandom_range(0, 2);
            ack   = $urandom_range(0, TMO + 2);
            if (ack > TMO) ack = -1;
            op = gen_op(c);
            run_instr($sformatf("rnd%0d", n), op, cnd, stall, ack,
                      model_exec(c, op, cnd), model_end(c), term);
            if (term) do_reset($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle successor to the single-cycle combinational instruction controller. Sequences each instruction through fetch, decode, execute and optional memory phases. Uses valid/ack handshakes toward instruction and data memory, a branch condition input, halt and illegal-opcode detection, and a memory-wait timeout. Sits between the instruction register/memory interface and the datapath (ALU, register file, PC mux).

## Interface
- `INSTR_W`, default 16: instruction width, ≥6; opcode is `instruction[INSTR_W-1 -: 6]`.
- `ALU_OP_W`, default 3: ALU op width, 1..4; `alu_op = opcode[ALU_OP_W-1:0]`.
- `MEM_TIMEOUT`, default 15: max MEM cycles without `mem_ack` before ERROR, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE; sampled only in IDLE.
- `instr_valid` in 1: instruction bus holds a valid word.
- `instruction` in INSTR_W: fetched word.
- `cond` in 1: branch condition flag, sampled in EXEC.
- `mem_ack` in 1: data memory completes the request.
- `instr_req` out 1: fetch request.
- `alu_op` out ALU_OP_W: ALU operation.
- `sel_ALUScr_reg`, `sel_ALUScr_const` out 1 each: ALU B-source selects.
- `sel_PCSrc_plus1`, `sel_PCSrc_offset`, `sel_PCSrc_const` out 1 each: PC source selects, one-hot or all zero.
- `pc_we`, `rf_we` out 1 each: PC / register-file write enables.
- `mem_req`, `mem_we` out 1 each: data memory request / write.
- `halted`, `error` out 1 each: sticky status.

## Operation
- Opcode classes, disjoint:
  - `00xxxx` = R.
  - `01xxxx` = I.
  - `100xxx` = CJ (conditional jump).
  - `1010xx` = J (jump).
  - `101100` = LD.
  - `101101` = ST.
  - `111111` = HALT.
  - All others = ILLEGAL.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT, ERROR. Opcode register (6 b) and wait counter (width clog2(MEM_TIMEOUT+1)) are internal.
- IDLE: all outputs 0. `start`=1 → FETCH.
- FETCH: `instr_req`=1. If `instr_valid`=1, capture opcode → DECODE. Otherwise stay.
- DECODE: no outputs asserted. HALT class → HALT; ILLEGAL → ERROR; else → EXEC.
- EXEC, R: `sel_ALUScr_reg`, `alu_op`, `rf_we`, `pc_we`, `sel_PCSrc_plus1` → FETCH.
- EXEC, I: same as R, with `sel_ALUScr_const` in place of `sel_ALUScr_reg` → FETCH.
- EXEC, CJ: `pc_we`. If `cond`=1, `sel_PCSrc_offset`; else `sel_PCSrc_plus1` → FETCH.
- EXEC, J: `pc_we`, `sel_PCSrc_const` → FETCH.
- EXEC, LD/ST: `sel_ALUScr_const`, `alu_op`=0 (address add); clear wait counter → MEM.
- MEM: `mem_req`=1, `mem_we`=1 for ST. `sel_ALUScr_const`=1 and `alu_op`=0 are held so the address stays stable.
  - On `mem_ack`=1, same cycle: `pc_we`, `sel_PCSrc_plus1`, `rf_we` (LD only) → FETCH.
  - Without ack, counter increments. When counter reaches MEM_TIMEOUT with no ack in that cycle → ERROR.
  - Ack in the final allowed cycle wins over timeout.
- HALT: `halted`=1, all other outputs 0, held until `rst`.
- ERROR: `error`=1, all other outputs 0, held until `rst`.
- `alu_op` is 0 in every state/class not listed above. Select outputs not listed are 0.

## Timing
- Reset: after the `rst` cycle, state=IDLE, opcode=0, counter=0, every output 0. `rst` has priority over all inputs, mid-instruction included; no partial `pc_we`/`rf_we`/`mem_req` in the following cycle.
- Outputs are functions of registered state and opcode, except EXEC CJ selects (`cond`) and MEM completion strobes (`mem_ack`), which are combinational from those inputs.
- Latency, `instr_valid` already high:
  - R/I/CJ/J: 3 cycles (FETCH, DECODE, EXEC).
  - LD/ST: 4 + wait cycles.
  - HALT/ILLEGAL: reach HALT/ERROR 2 cycles after fetch accept.
- `instruction` is only sampled in the FETCH cycle with `instr_valid`=1. Later changes are ignored.
- `start` outside IDLE, `mem_ack` outside MEM and `cond` outside EXEC-CJ are ignored.
- ERROR entry: exactly MEM_TIMEOUT+1 MEM cycles without ack → ERROR on the next edge.

## Test plan
- Reset, `start`, then R opcode `000101` with `ALU_OP_W`=3 → EXEC cycle shows `alu_op`=5, `sel_ALUScr_reg`=1, `rf_we`=`pc_we`=`sel_PCSrc_plus1`=1; back in FETCH 3 cycles after accept.
- CJ `100010` with `cond`=1, then again with `cond`=0 → `sel_PCSrc_offset`=1, then `sel_PCSrc_plus1`=1; `pc_we`=1 both times, `rf_we`=0.
- LD `101100`, `mem_ack` after 3 MEM cycles → `mem_req`=1 for 3 cycles, `mem_we`=0, `rf_we`+`pc_we` only in the ack cycle. ST `101101` with ack in the first cycle → `mem_we`=1, `rf_we`=0.
- ST with no ack, `MEM_TIMEOUT`=15 → `mem_req` for 16 cycles, then `error`=1 sticky. Ack in cycle 16 instead → no error.
- HALT `111111` → `halted`=1 stays. ILLEGAL `110000` → `error`=1. Asserting `start`, `instr_valid` or `mem_ack` afterwards has no effect until `rst`.
- `rst` asserted during MEM of an LD and during FETCH stall → next cycle all outputs 0, state IDLE. A fresh `start` runs normally.
